psk_mod_tx: RTL and testbench
=============================

Name: psk_mod_tx

Overview:
- BPSK/QPSK baseband modulator: the transmit-side counterpart of the PSK demodulator in the Rx chain.
- Accepts symbol bits over a valid/ready handshake and maps each symbol to a signed I/Q constellation point.
- Holds each point for SPS samples at 16.384 MHz and drives the DAC_I/DAC_Q loopback/DAC path.
- A programmable start delay (DELAY_CNT) offsets the first symbol, so Rx timing recovery is exercised at different phases.

Parameters:
- SPS, 16, samples per symbol (16.384 MHz / 1.024 MHz); legal range 2..64.
- DW, 12, DAC sample width, signed two's complement.
- AMP, 1024, BPSK amplitude; the QPSK per-rail amplitude AMP_Q = (AMP*181)>>8, which is 724 at default.

Ports:
- clk_16M384  in  1  sample clock.
- rst_n_16M384  in  1  reset, asynchronous, active-low.
- is_bpsk  in  1  1 = BPSK, 0 = QPSK; sampled on bit accept.
- DELAY_CNT  in  4  idle-to-first-symbol delay, in clocks.
- bits_in  in  2  symbol bits; BPSK uses bits_in[0] only.
- bits_vld  in  1  bits_in valid.
- bits_rdy  out  1  block can accept bits this cycle.
- DAC_I  out  DW  signed I sample.
- DAC_Q  out  DW  signed Q sample.
- DAC_bits  out  2  bits of the symbol currently on DAC_I/Q; for BPSK, {1'b0, b0}.
- DAC_vld  out  1  DAC_I/Q carry a symbol sample.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - State = IDLE, sample counter = 0.
  - DAC_I = DAC_Q = 0, DAC_bits = 0, DAC_vld = 0, busy = 0.
  - bits_rdy = 1 once reset is released.
- FSM states: IDLE, DELAY, SYMBOL.
- IDLE:
  - bits_rdy = 1; outputs are 0, DAC_vld = 0.
  - On accept (bits_vld & bits_rdy), latch bits and is_bpsk, then:
    - DELAY_CNT != 0: go to DELAY, delay counter loaded with DELAY_CNT-1.
    - DELAY_CNT == 0: go to SYMBOL.
- DELAY:
  - bits_rdy = 0; outputs held at 0, DAC_vld = 0.
  - Counter decrements; at 0, go to SYMBOL.
- SYMBOL:
  - Registered outputs carry the mapped point with DAC_vld = 1 for exactly SPS consecutive cycles; sample counter runs 0..SPS-1.
  - bits_rdy = 1 only when counter == SPS-1.
  - Accept on that cycle: the next symbol starts on the following cycle, counter wraps to 0, no delay applied. DAC_vld stays continuously high.
  - No accept at SPS-1: go to IDLE; outputs return to 0 and DAC_vld = 0 on the next cycle.
- Latency: accept at cycle N gives the first DAC_vld at cycle N+1+DELAY_CNT. For back-to-back symbols, zero bubble cycles.
- Mapping (bit 0 maps to +, bit 1 maps to -):
  - BPSK: DAC_I = b0 ? -AMP : +AMP; DAC_Q = 0.
  - QPSK: DAC_I = b1 ? -AMP_Q : +AMP_Q; DAC_Q = b0 ? -AMP_Q : +AMP_Q.
  - All values are sign-extended to DW. AMP must satisfy AMP < 2^(DW-1), which makes negation overflow-free.
- Mid-symbol inputs:
  - is_bpsk and DELAY_CNT changes mid-symbol have no effect until the next accept.
  - bits_vld pulses while bits_rdy = 0 are ignored; no data loss is allowed for the upstream, which must hold bits_vld.
- Reset mid-symbol: outputs clear immediately (asynchronous); any in-flight symbol is discarded.

Optional Feature:
- Macro: PSK_MOD_SCRAMBLE_EN.
- Defined:
  - Each accepted bit is XORed with a PRBS7 output (x^7+x^6+1, seed 7'h7F, loaded at reset).
  - The LFSR advances once per bit consumed: 1 step per BPSK symbol, 2 steps per QPSK symbol (bits_in[1] first).
  - DAC_bits reports the scrambled bits.
- Undefined: no LFSR logic; bits map directly.

Test Plan:
- Single BPSK symbol: bits_in=2'b00, DELAY_CNT=0, accept at cycle N -> DAC_I=+1024, DAC_Q=0, DAC_vld=1 on cycles N+1..N+16; then IDLE with outputs 0.
- Delay: BPSK bit 1, DELAY_CNT=8 -> DAC_vld low for 8 cycles, then DAC_I=-1024 for 16 cycles.
- Back-to-back QPSK: bits 00,11,10 offered continuously -> (I,Q) = (724,724), (-724,-724), (-724,724), each for 16 cycles; DAC_vld continuously high for 48 cycles; bits_rdy pulses only at counter 15.
- Mode latch: is_bpsk toggled 1→0 mid-symbol -> current BPSK symbol unaffected; the next accept uses QPSK mapping.
- Reset mid-symbol: rst_n low at sample 5 -> DAC_I/Q=0, DAC_vld=0 within the same cycle; after release, bits_rdy=1 and state IDLE.
- With PSK_MOD_SCRAMBLE_EN: BPSK all-zero input -> DAC_bits[0] sequence equals the PRBS7 output from seed 7'h7F, period 127 symbols.

Source files
------------

// File: rtl/psk_mod_tx.sv
// psk_mod_tx: BPSK/QPSK baseband modulator. Each accepted symbol is held for SPS samples on DAC_I/Q.
// Optional PSK_MOD_SCRAMBLE_EN XORs accepted bits with a PRBS7 (x^7+x^6+1, seed 7'h7F).
module psk_mod_tx #(
   parameter int unsigned SPS = 16,
   parameter int unsigned DW  = 12,
   parameter int unsigned AMP = 1024
) (
   input  logic                 clk_16M384,
   input  logic                 rst_n_16M384,
   input  logic                 is_bpsk,
   input  logic [3:0]           DELAY_CNT,
   input  logic [1:0]           bits_in,
   input  logic                 bits_vld,
   output logic                 bits_rdy,
   output logic signed [DW-1:0] DAC_I,
   output logic signed [DW-1:0] DAC_Q,
   output logic [1:0]           DAC_bits,
   output logic                 DAC_vld,
   output logic                 busy
);
   localparam int unsigned          CntW    = (SPS > 1) ? $clog2(SPS) : 1;
   localparam logic [CntW-1:0]      CntLast = CntW'(SPS - 1);
   localparam logic signed [DW-1:0] AmpB    = DW'(AMP);
   localparam logic signed [DW-1:0] AmpQ    = DW'((AMP * 181) >> 8);

   typedef enum logic [1:0] {StIdle, StDelay, StSymbol} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [3:0]           dly_q, dly_d;
   logic [1:0]           bits_q, bits_d;
   logic                 bpsk_q, bpsk_d;
   logic signed [DW-1:0] dac_i_q, dac_i_d, dac_q_q, dac_q_d;
   logic [1:0]           dac_bits_q, dac_bits_d;
   logic                 dac_vld_q, dac_vld_d;
   logic                 accept, start;
   logic [1:0]           acc_bits;

   assign bits_rdy = rst_n_16M384 &
                     ((state_q == StIdle) | ((state_q == StSymbol) & (cnt_q == CntLast)));
   assign accept   = bits_vld & bits_rdy;

`ifdef PSK_MOD_SCRAMBLE_EN
   logic [6:0] lfsr_q, lfsr_d, lfsr_1, lfsr_2;

   // One LFSR step per consumed bit; QPSK consumes bits_in[1] first.
   always_comb begin
      lfsr_1 = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
      lfsr_2 = {lfsr_1[5:0], lfsr_1[6] ^ lfsr_1[5]};
      if (is_bpsk) begin
         acc_bits = {1'b0, bits_in[0] ^ lfsr_1[0]};
         lfsr_d   = accept ? lfsr_1 : lfsr_q;
      end else begin
         acc_bits = bits_in ^ {lfsr_1[0], lfsr_2[0]};
         lfsr_d   = accept ? lfsr_2 : lfsr_q;
      end
   end
`else
   assign acc_bits = is_bpsk ? {1'b0, bits_in[0]} : bits_in;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dly_d   = dly_q;
      bits_d  = bits_q;
      bpsk_d  = bpsk_q;
      start   = 1'b0;
      if (accept) begin
         bits_d = acc_bits;
         bpsk_d = is_bpsk;
      end
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (DELAY_CNT != 4'd0) begin
                  state_d = StDelay;
                  dly_d   = DELAY_CNT - 4'd1;
               end else begin
                  start = 1'b1;
               end
            end
         end
         StDelay: begin
            if (dly_q == 4'd0) start = 1'b1;
            else               dly_d = dly_q - 4'd1;
         end
         StSymbol: begin
            if (cnt_q == CntLast) begin
               if (accept) start = 1'b1;
               else        state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
      if (start) begin
         state_d = StSymbol;
         cnt_d   = '0;
      end

      // Outputs are registered: they reflect the point of the state being entered.
      if (bpsk_d) begin
         dac_i_d = bits_d[0] ? -AmpB : AmpB;
         dac_q_d = '0;
      end else begin
         dac_i_d = bits_d[1] ? -AmpQ : AmpQ;
         dac_q_d = bits_d[0] ? -AmpQ : AmpQ;
      end
      dac_bits_d = bits_d;
      dac_vld_d  = (state_d == StSymbol);
      if (state_d != StSymbol) begin
         dac_i_d    = '0;
         dac_q_d    = '0;
         dac_bits_d = 2'b00;
      end
   end

   always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
      if (!rst_n_16M384) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         dly_q      <= 4'd0;
         bits_q     <= 2'b00;
         bpsk_q     <= 1'b0;
         dac_i_q    <= '0;
         dac_q_q    <= '0;
         dac_bits_q <= 2'b00;
         dac_vld_q  <= 1'b0;
`ifdef PSK_MOD_SCRAMBLE_EN
         lfsr_q     <= 7'h7F;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dly_q      <= dly_d;
         bits_q     <= bits_d;
         bpsk_q     <= bpsk_d;
         dac_i_q    <= dac_i_d;
         dac_q_q    <= dac_q_d;
         dac_bits_q <= dac_bits_d;
         dac_vld_q  <= dac_vld_d;
`ifdef PSK_MOD_SCRAMBLE_EN
         lfsr_q     <= lfsr_d;
`endif
      end
   end

   assign DAC_I    = dac_i_q;
   assign DAC_Q    = dac_q_q;
   assign DAC_bits = dac_bits_q;
   assign DAC_vld  = dac_vld_q;
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_psk_mod_tx.sv
// Bench for psk_mod_tx: a per-cycle expected timeline (filled at each accept) checked every cycle,
// plus hand-computed literal checks. PSK_MOD_SCRAMBLE_EN also enables the PRBS7 model.
`timescale 1ns/1ps
module tb_psk_mod_tx;
   localparam int SPS  = 16;
   localparam int DW   = 12;
   localparam int AMP  = 1024;
   localparam int AMPQ = (AMP * 181) / 256;
   localparam int MAXC = 8000;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 is_bpsk = 1'b1;
   logic [3:0]           delay_cnt = 4'd0;
   logic [1:0]           bits_in = 2'b00;
   logic                 bits_vld = 1'b0;
   logic                 bits_rdy, dac_vld, busy;
   logic signed [DW-1:0] dac_i, dac_q;
   logic [1:0]           dac_bits;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   in_rst = 1'b1;
   int   run_len = 0;
   int   max_run = 0;
   logic [6:0] prbs = 7'h7F;

   // Expected timeline, indexed by cycle number.
   int       e_i   [MAXC];
   int       e_q   [MAXC];
   logic [1:0] e_bits[MAXC];
   bit       e_vld [MAXC];
   bit       e_busy[MAXC];
   bit       e_occ [MAXC];   // busy and not the last sample of a symbol

   psk_mod_tx #(.SPS(SPS), .DW(DW), .AMP(AMP)) dut (
      .clk_16M384  (clk),
      .rst_n_16M384(rst_n),
      .is_bpsk     (is_bpsk),
      .DELAY_CNT   (delay_cnt),
      .bits_in     (bits_in),
      .bits_vld    (bits_vld),
      .bits_rdy    (bits_rdy),
      .DAC_I       (dac_i),
      .DAC_Q       (dac_q),
      .DAC_bits    (dac_bits),
      .DAC_vld     (dac_vld),
      .busy        (busy)
   );

   always #30 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cyc < MAXC) begin
         run_len = dac_vld ? run_len + 1 : 0;
         if (run_len > max_run) max_run = run_len;
         check("DAC_I", dac_i, e_i[cyc]);
         check("DAC_Q", dac_q, e_q[cyc]);
         check("DAC_bits", dac_bits, e_bits[cyc]);
         check("DAC_vld", dac_vld, e_vld[cyc]);
         check("busy", busy, e_busy[cyc]);
         check("bits_rdy", bits_rdy, (!in_rst && !e_occ[cyc]));
      end
   end

   task automatic prbs_bit(output logic b);
      b    = prbs[6] ^ prbs[5];
      prbs = {prbs[5:0], b};
   endtask

   task automatic model_clear(input int from);
      for (int c = from; c < MAXC; c++) begin
         e_i[c] = 0; e_q[c] = 0; e_bits[c] = 2'b00;
         e_vld[c] = 1'b0; e_busy[c] = 1'b0; e_occ[c] = 1'b0;
      end
   endtask

   // Accept seen during cycle t: optional delay, then SPS samples of the mapped point.
   task automatic model_accept(input int t, input logic bp, input logic [1:0] b, input int d);
      logic [1:0] s;
      logic       p;
      int         vi, vq, c;
      s = bp ? {1'b0, b[0]} : b;
      p = 1'b0;
`ifdef PSK_MOD_SCRAMBLE_EN
      if (bp) begin
         prbs_bit(p); s[0] = s[0] ^ p;
      end else begin
         prbs_bit(p); s[1] = s[1] ^ p;
         prbs_bit(p); s[0] = s[0] ^ p;
      end
`endif
      if (bp) begin
         vi = s[0] ? -AMP : AMP;
         vq = 0;
      end else begin
         vi = s[1] ? -AMPQ : AMPQ;
         vq = s[0] ? -AMPQ : AMPQ;
      end
      if (e_busy[t]) d = 0;   // chained onto the previous symbol
      for (int k = 1; k <= d; k++) begin
         if (t + k < MAXC) begin e_busy[t+k] = 1'b1; e_occ[t+k] = 1'b1; end
      end
      for (int k = 0; k < SPS; k++) begin
         c = t + 1 + d + k;
         if (c < MAXC) begin
            e_busy[c] = 1'b1; e_vld[c] = 1'b1; e_i[c] = vi; e_q[c] = vq;
            e_bits[c] = s; e_occ[c] = (k != SPS - 1);
         end
      end
   endtask

   // Holds bits_vld until the model says the DUT is ready, then scrambles the other inputs.
   task automatic send(input logic bp, input logic [1:0] b, input logic [3:0] d);
      int n;
      int t;
      n = 0;
      is_bpsk = bp; bits_in = b; delay_cnt = d; bits_vld = 1'b1;
      while ((in_rst || e_occ[cyc]) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout at cycle %0d: got no ready, expected ready", cyc);
         bits_vld = 1'b0;
      end else begin
         t = cyc;
         @(posedge clk); #1;
         model_accept(t, bp, b, int'(d));
         bits_vld = 1'b0; is_bpsk = ~bp; bits_in = ~b; delay_cnt = ~d;
      end
   endtask

   initial begin
      model_clear(0);
      repeat (3) @(posedge clk);
      #1; rst_n = 1'b1; in_rst = 1'b0;
      @(negedge clk);
      check("rdy_after_reset", bits_rdy, 1);
      check("vld_after_reset", dac_vld, 0);

      // Single BPSK symbol, no delay
      send(1'b1, 2'b00, 4'd0);
`ifndef PSK_MOD_SCRAMBLE_EN
      @(negedge clk);
      check("bpsk0_first_I", dac_i, 1024);
      check("bpsk0_first_Q", dac_q, 0);
      check("bpsk0_first_vld", dac_vld, 1);
      repeat (15) @(negedge clk);
      check("bpsk0_last_I", dac_i, 1024);
      @(negedge clk);
      check("bpsk0_after_vld", dac_vld, 0);
      check("bpsk0_after_I", dac_i, 0);
`endif
      repeat (4) @(negedge clk);

      // BPSK bit 1 with an 8-cycle start delay
      send(1'b1, 2'b01, 4'd8);
`ifndef PSK_MOD_SCRAMBLE_EN
      repeat (8) @(negedge clk);
      check("delay_last_vld", dac_vld, 0);
      check("delay_last_busy", busy, 1);
      @(negedge clk);
      check("delay_first_I", dac_i, -1024);
`endif
      repeat (30) @(negedge clk);

      // Back-to-back QPSK 00, 11, 10
      max_run = 0;
      send(1'b0, 2'b00, 4'd0);
`ifndef PSK_MOD_SCRAMBLE_EN
      @(negedge clk);
      check("qpsk00_I", dac_i, 724);
      check("qpsk00_Q", dac_q, 724);
`endif
      send(1'b0, 2'b11, 4'd0);
      send(1'b0, 2'b10, 4'd5);
`ifndef PSK_MOD_SCRAMBLE_EN
      @(negedge clk);
      check("qpsk10_I", dac_i, -724);
      check("qpsk10_Q", dac_q, 724);
`endif
      repeat (20) @(negedge clk);
      check("qpsk_vld_run", max_run, 48);

      // Mode latch: BPSK symbol, then a chained QPSK one
      send(1'b1, 2'b01, 4'd0);
      send(1'b0, 2'b01, 4'd3);
`ifndef PSK_MOD_SCRAMBLE_EN
      @(negedge clk);
      check("mode_qpsk_I", dac_i, 724);
      check("mode_qpsk_Q", dac_q, -724);
      check("mode_qpsk_bits", dac_bits, 1);
`endif
      repeat (20) @(negedge clk);

      // Reset at sample 5 of a symbol
      send(1'b1, 2'b00, 4'd0);
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 1'b0; in_rst = 1'b1; prbs = 7'h7F;
      model_clear(cyc);
      #1;
      check("rst_vld", dac_vld, 0);
      check("rst_I", dac_i, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1; in_rst = 1'b0;
      @(negedge clk);
      check("rst_release_rdy", bits_rdy, 1);
      check("rst_release_busy", busy, 0);

      // Directed mix of modes, delays and chaining
      send(1'b0, 2'b01, 4'd15);
      send(1'b1, 2'b11, 4'd1);
      send(1'b0, 2'b11, 4'd0);
      send(1'b0, 2'b10, 4'd2);
      repeat (25) @(negedge clk);
      send(1'b1, 2'b10, 4'd1);
      repeat (25) @(negedge clk);

`ifdef PSK_MOD_SCRAMBLE_EN
      // All-zero BPSK stream over more than one PRBS7 period
      for (int k = 0; k < 130; k++) send(1'b1, 2'b00, 4'd0);
`endif
      repeat (40) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
